gray_decode_mc: RTL

//   Multi-channel pipelined Gray-to-binary decoder, the parametrised successor of the single 10-bit decoder.

---
 rtl/gray_decode_mc_if.sv | 27 ++
 rtl/gray_decode_mc.sv | 120 ++++++++++++
 2 files changed

// File: rtl/gray_decode_mc_if.sv
// Sample/result bus of the multi-channel Gray decoder.
// The master side presents Gray snapshots and the sticky-clear pulse;
// the slave side (the decoder) returns decoded values, deltas and error flags.
interface gray_decode_mc_if #(
    parameter int WIDTH = 10,
    parameter int NCH   = 4
) ();
    logic                  in_valid;
    logic [NCH*WIDTH-1:0]  gray_in;
    logic                  err_clr;
    logic                  out_valid;
    logic [NCH*WIDTH-1:0]  bin_out;
    logic [NCH*WIDTH-1:0]  delta_out;
    logic [NCH-1:0]        err_out;
    logic [NCH-1:0]        err_sticky;
    logic                  out_first;

    modport master (
        output in_valid, gray_in, err_clr,
        input  out_valid, bin_out, delta_out, err_out, err_sticky, out_first
    );

    modport slave (
        input  in_valid, gray_in, err_clr,
        output out_valid, bin_out, delta_out, err_out, err_sticky, out_first
    );
endinterface

// File: rtl/gray_decode_mc.sv
// Multi-channel two-stage Gray-to-binary decoder.
// Stage 1 captures the snapshot and flags Gray steps of more than one bit;
// stage 2 converts to binary and computes the per-channel increment.
module gray_decode_mc #(
    parameter int WIDTH = 10,
    parameter int NCH   = 4
) (
    input  logic             clk,
    input  logic             rst,
    gray_decode_mc_if.slave  bus
);
    // Stage 1 state
    logic                  s1_valid;
    logic                  s1_first;
    logic [NCH*WIDTH-1:0]  s1_gray;
    logic [NCH-1:0]        s1_err;
    logic                  has_prev;
    logic [NCH*WIDTH-1:0]  prev_gray;

    // Stage 2 / output state
    logic                  out_valid_r;
    logic                  first_r;
    logic [NCH*WIDTH-1:0]  bin_r;
    logic [NCH*WIDTH-1:0]  delta_r;
    logic [NCH-1:0]        err_r;
    logic [NCH-1:0]        sticky_r;
    logic [NCH*WIDTH-1:0]  prev_bin;

    // Combinational results feeding the two register stages
    logic [NCH-1:0]        hd_err;
    logic [NCH*WIDTH-1:0]  bin_nxt;
    logic [NCH*WIDTH-1:0]  delta_nxt;
    logic [WIDTH-1:0]      x;
    logic                  acc;

    // Per-channel Hamming check on the incoming word and prefix-XOR decode of stage 1
    always_comb begin
        // NOTE: every signal gets a default before any branch or loop so no latch is inferred.
        hd_err    = '0;
        bin_nxt   = '0;
        delta_nxt = '0;
        x         = '0;
        acc       = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            // More than one bit set in x means the Gray code jumped.
            x         = bus.gray_in[c*WIDTH +: WIDTH] ^ prev_gray[c*WIDTH +: WIDTH];
            hd_err[c] = has_prev && ((x & (x - WIDTH'(1))) != '0);

            // Binary bit i is the XOR of all Gray bits from the MSB down to i.
            acc = 1'b0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                acc                  = acc ^ s1_gray[c*WIDTH + i];
                bin_nxt[c*WIDTH + i] = acc;
            end
            // Subtraction wraps naturally at WIDTH bits.
            delta_nxt[c*WIDTH +: WIDTH] = s1_first ? '0
                : bin_nxt[c*WIDTH +: WIDTH] - prev_bin[c*WIDTH +: WIDTH];
        end
    end

    // Stage 1: capture qualified snapshots and remember them for the next Hamming check
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_gray   <= '0;
            s1_err    <= '0;
            has_prev  <= 1'b0;
            prev_gray <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_gray   <= bus.gray_in;
                s1_err    <= hd_err;
                s1_first  <= !has_prev;
                prev_gray <= bus.gray_in;
                // Set on acceptance so a back-to-back follower already sees a predecessor.
                has_prev  <= 1'b1;
            end
        end
    end

    // Stage 2: publish decoded values and deltas; data holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            first_r     <= 1'b0;
            bin_r       <= '0;
            delta_r     <= '0;
            err_r       <= '0;
            prev_bin    <= '0;
        end else begin
            out_valid_r <= s1_valid;
            if (s1_valid) begin
                bin_r    <= bin_nxt;
                delta_r  <= delta_nxt;
                err_r    <= s1_err;
                first_r  <= s1_first;
                prev_bin <= bin_nxt;
            end
        end
    end

    // Sticky error accumulation; a fresh error wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= '0;
        end else begin
            sticky_r <= (bus.err_clr ? '0 : sticky_r) | (out_valid_r ? err_r : '0);
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.bin_out    = bin_r;
    assign bus.delta_out  = delta_r;
    assign bus.err_out    = err_r;
    assign bus.err_sticky = sticky_r;
    assign bus.out_first  = first_r;
endmodule
